commutation_ctrl: RTL and testbench

COMMUTATION_CTRL -- requirements
Module: commutation_ctrl

---
 rtl/comm_pkg.sv | 31 +++
 rtl/dwell_timer.sv | 48 ++++
 rtl/commutation_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_commutation_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// comm_pkg
// Shared definitions for the four-step commutation controller of one
// matrix-converter output leg: the controller state encoding, the default
// dwell time of each intermediate commutation step, and the width helper for
// the dwell counter.
// Ports: none (package).
package comm_pkg;

    // Controller states. ST_OFF2 names the closing action of a turn-off
    // (remaining gate released, leg back in IDLE); that action is taken on the
    // same edge that ends OFF1, so the register never rests in ST_OFF2.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ON    = 3'd1,
        ST_STEP1 = 3'd2,
        ST_STEP2 = 3'd3,
        ST_STEP3 = 3'd4,
        ST_OFF1  = 3'd5,
        ST_OFF2  = 3'd6,
        ST_FAULT = 3'd7
    } comm_state_e;

    // Default number of clock cycles each intermediate step is held.
    localparam int DWELL_CYC_DEFAULT = 4;

    // Counter width able to hold the value dwell_cyc.
    function automatic int dwell_cnt_w(input int dwell_cyc);
        return $clog2(dwell_cyc + 1);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer
// Down-counter that times one intermediate commutation step.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset, clears the count
//   load_i   - (re)start a dwell of DWELL_CYC cycles on this edge
//   expire_o - high during the last cycle of the dwell; the owner acts on
//              the edge that ends that cycle
module dwell_timer
    import comm_pkg::*;
#(
    parameter int  DWELL_CYC = DWELL_CYC_DEFAULT,
    localparam int CNT_W     = dwell_cnt_w(DWELL_CYC)
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DWELL_CYC);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Loading DWELL_CYC and expiring at 1 gives exactly DWELL_CYC cycles
    // between the loading edge and the edge that ends the step.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == ONE);

endmodule

// File: rtl/commutation_ctrl.sv
// commutation_ctrl
// Four-step current-sign-based commutation controller for one output leg of a
// matrix converter. Each input phase has a bidirectional switch made of a
// positive-conducting device (gate_p) and a negative-conducting device
// (gate_n). Source changes are performed so the leg is never open-circuited
// for the load current and never short-circuits two input phases.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   req_valid - a source-change request is present
//   req_sel   - target phase 0..N_PHASES-1, N_PHASES = leg off, above = invalid
//   cur_sign  - load current sign (1 = positive), sampled on acceptance
//   req_ready - high in IDLE or ON; requests are accepted only then
//   gate_p    - registered positive-device gates, one per phase
//   gate_n    - registered negative-device gates, one per phase
//   done      - one-cycle pulse when a request completes
//   fault     - an invalid request was accepted; all gates held off
//   fault_clr - leaves the fault state (ignored elsewhere)
module commutation_ctrl
    import comm_pkg::*;
#(
    parameter int  N_PHASES  = 3,
    parameter int  DWELL_CYC = DWELL_CYC_DEFAULT,
    localparam int SEL_W     = $clog2(N_PHASES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [SEL_W-1:0]    req_sel,
    input  logic                cur_sign,
    output logic                req_ready,
    output logic [N_PHASES-1:0] gate_p,
    output logic [N_PHASES-1:0] gate_n,
    output logic                done,
    output logic                fault,
    input  logic                fault_clr
);

    comm_state_e         state_q;
    logic [N_PHASES-1:0] gate_p_q;
    logic [N_PHASES-1:0] gate_n_q;
    logic                done_q;
    logic                fault_q;
    logic [SEL_W-1:0]    j_q;       // phase currently supplying the leg
    logic [SEL_W-1:0]    k_q;       // target phase of the running sequence
    logic                s_q;       // current sign latched at acceptance

    logic [N_PHASES-1:0] j_mask;
    logic [N_PHASES-1:0] k_mask;
    logic [N_PHASES-1:0] sel_mask;

    logic accept;
    logic sel_bad;
    logic sel_off;
    logic sel_same;
    logic timer_load;
    logic timer_expire;

    // One-hot masks of the current source, the latched target and the
    // incoming request.
    for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_mask
        assign j_mask[gi]   = (j_q == SEL_W'(gi));
        assign k_mask[gi]   = (k_q == SEL_W'(gi));
        assign sel_mask[gi] = (req_sel == SEL_W'(gi));
    end

    assign req_ready = (state_q == ST_IDLE) || (state_q == ST_ON);
    assign accept    = req_valid && req_ready;

    // Compared as int so the test stays meaningful when N_PHASES+1 is a
    // power of two and no invalid code exists.
    assign sel_bad   = int'(req_sel) > N_PHASES;
    assign sel_off   = int'(req_sel) == N_PHASES;
    assign sel_same  = (state_q == ST_ON) && (req_sel == j_q);

    // The timer is started on entry to STEP1 / OFF1 and restarted on each
    // step-to-step transition; the final action of a sequence needs no dwell.
    assign timer_load = (accept && (state_q == ST_ON) && !sel_bad && !sel_same)
                     || (timer_expire && ((state_q == ST_STEP1) || (state_q == ST_STEP2)));

    dwell_timer #(
        .DWELL_CYC (DWELL_CYC)
    ) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (timer_load),
        .expire_o (timer_expire)
    );

    // In the sequences below "conducting" means the device of the latched
    // sign (gate_p for s=1, gate_n for s=0) and "idle" the other device.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            gate_p_q <= '0;
            gate_n_q <= '0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            j_q      <= '0;
            k_q      <= '0;
            s_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (sel_bad) begin
                            state_q  <= ST_FAULT;
                            gate_p_q <= '0;
                            gate_n_q <= '0;
                            fault_q  <= 1'b1;
                        end else if (sel_off) begin
                            done_q <= 1'b1;
                        end else begin
                            // No source to hand over from: close both devices.
                            gate_p_q <= sel_mask;
                            gate_n_q <= sel_mask;
                            j_q      <= req_sel;
                            done_q   <= 1'b1;
                            state_q  <= ST_ON;
                        end
                    end
                end

                ST_ON: begin
                    if (accept) begin
                        if (sel_bad) begin
                            state_q  <= ST_FAULT;
                            gate_p_q <= '0;
                            gate_n_q <= '0;
                            fault_q  <= 1'b1;
                        end else if (sel_same) begin
                            done_q <= 1'b1;
                        end else begin
                            k_q <= req_sel;
                            s_q <= cur_sign;
                            // Commutation and turn-off both start by opening
                            // the idle device of the present source; the sign
                            // is taken straight from the input on this edge.
                            if (cur_sign) begin
                                gate_n_q <= gate_n_q & ~j_mask;
                            end else begin
                                gate_p_q <= gate_p_q & ~j_mask;
                            end
                            state_q <= sel_off ? ST_OFF1 : ST_STEP1;
                        end
                    end
                end

                ST_STEP1: begin
                    if (timer_expire) begin
                        // Close the conducting device of the target.
                        if (s_q) begin
                            gate_p_q <= gate_p_q | k_mask;
                        end else begin
                            gate_n_q <= gate_n_q | k_mask;
                        end
                        state_q <= ST_STEP2;
                    end
                end

                ST_STEP2: begin
                    if (timer_expire) begin
                        // Open the conducting device of the old source.
                        if (s_q) begin
                            gate_p_q <= gate_p_q & ~j_mask;
                        end else begin
                            gate_n_q <= gate_n_q & ~j_mask;
                        end
                        state_q <= ST_STEP3;
                    end
                end

                ST_STEP3: begin
                    if (timer_expire) begin
                        // Close the idle device of the target: fully on.
                        if (s_q) begin
                            gate_n_q <= gate_n_q | k_mask;
                        end else begin
                            gate_p_q <= gate_p_q | k_mask;
                        end
                        j_q     <= k_q;
                        done_q  <= 1'b1;
                        state_q <= ST_ON;
                    end
                end

                ST_OFF1: begin
                    if (timer_expire) begin
                        // Only the conducting device of j is still closed.
                        gate_p_q <= '0;
                        gate_n_q <= '0;
                        done_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end

                ST_FAULT: begin
                    if (fault_clr) begin
                        fault_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    // ST_OFF2 is never held; recover to a safe, open leg.
                    gate_p_q <= '0;
                    gate_n_q <= '0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign gate_p = gate_p_q;
    assign gate_n = gate_n_q;
    assign done   = done_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_commutation_ctrl.sv
// tb_commutation_ctrl
// Drives two controller instances (3 phases / dwell 4, 5 phases / dwell 3)
// with directed and random requests. A transaction-level model turns each
// accepted request into the list of gate/done/ready/fault values expected in
// every following cycle, which are compared at the falling clock edge.
module tb_commutation_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst3 = 1'b1, req_valid3 = 1'b0, cur_sign3 = 1'b0, fault_clr3 = 1'b0;
    logic [1:0] req_sel3 = '0;
    logic       req_ready3, done3, fault3;
    logic [2:0] gate_p3, gate_n3;

    logic       rst5 = 1'b1, req_valid5 = 1'b0, cur_sign5 = 1'b0, fault_clr5 = 1'b0;
    logic [2:0] req_sel5 = '0;
    logic       req_ready5, done5, fault5;
    logic [4:0] gate_p5, gate_n5;

    commutation_ctrl #(.N_PHASES(3), .DWELL_CYC(4)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_sel(req_sel3),
        .cur_sign(cur_sign3), .req_ready(req_ready3), .gate_p(gate_p3),
        .gate_n(gate_n3), .done(done3), .fault(fault3), .fault_clr(fault_clr3)
    );

    commutation_ctrl #(.N_PHASES(5), .DWELL_CYC(3)) dut5 (
        .clk(clk), .rst(rst5), .req_valid(req_valid5), .req_sel(req_sel5),
        .cur_sign(cur_sign5), .req_ready(req_ready5), .gate_p(gate_p5),
        .gate_n(gate_n5), .done(done5), .fault(fault5), .fault_clr(fault_clr5)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model parameters and state per instance (0 = 3-phase, 1 = 5-phase).
    int         n_ph[2] = '{3, 5};
    int         dw[2]   = '{4, 3};
    logic [7:0] m_gp[2];
    logic [7:0] m_gn[2];
    bit         m_on[2];
    int         m_j[2];

    // Expected per-cycle observations and "pulse fault_clr after this cycle".
    logic [31:0] exp_q[$];
    bit          clr_q[$];

    function automatic logic [31:0] pack_obs(logic [7:0] p, logic [7:0] n, bit d, bit r, bit f);
        return {13'd0, f, r, d, n, p};
    endfunction

    function automatic logic [31:0] sample(int w);
        if (w == 0) return pack_obs(8'(gate_p3), 8'(gate_n3), done3, req_ready3, fault3);
        return pack_obs(8'(gate_p5), 8'(gate_n5), done5, req_ready5, fault5);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%05h want=%05h (fault,ready,done,gate_n,gate_p)", tag, got, want);
        end
    endtask

    function automatic void push(logic [7:0] p, logic [7:0] n, bit d, bit r, bit f, bit c);
        exp_q.push_back(pack_obs(p, n, d, r, f));
        clr_q.push_back(c);
    endfunction

    // c = conducting-device gates, o = idle-device gates for sign s.
    function automatic void push_cs(bit s, logic [7:0] c, logic [7:0] o, bit d, bit r);
        if (s) push(c, o, d, r, 1'b0, 1'b0);
        else   push(o, c, d, r, 1'b0, 1'b0);
    endfunction

    task automatic drive(int w, bit v, int sel, bit sign, bit clr);
        if (w == 0) begin
            req_valid3 = v; req_sel3 = 2'(sel); cur_sign3 = sign; fault_clr3 = clr;
        end else begin
            req_valid5 = v; req_sel5 = 3'(sel); cur_sign5 = sign; fault_clr5 = clr;
        end
    endtask

    task automatic set_rst(int w, bit v);
        if (w == 0) rst3 = v;
        else        rst5 = v;
    endtask

    function automatic void model_clear(int w);
        m_on[w] = 1'b0;
        m_j[w]  = 0;
        m_gp[w] = '0;
        m_gn[w] = '0;
    endfunction

    // Idle cycles: nothing requested, fault_clr and cur_sign wiggled.
    task automatic idle_cycles(int w, int n);
        for (int i = 0; i < n; i++) begin
            drive(w, 1'b0, $urandom_range(0, 7), 1'($urandom), 1'($urandom));
            @(negedge clk);
            check_eq($sformatf("d%0d hold", w), sample(w), pack_obs(m_gp[w], m_gn[w], 1'b0, 1'b1, 1'b0));
        end
        drive(w, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(int w);
        @(negedge clk);
        #2;
        set_rst(w, 1'b0);
        #1;
        check_eq($sformatf("d%0d rst_async", w), sample(w), pack_obs('0, '0, 1'b0, 1'b1, 1'b0));
        @(negedge clk);
        check_eq($sformatf("d%0d rst_held", w), sample(w), pack_obs('0, '0, 1'b0, 1'b1, 1'b0));
        set_rst(w, 1'b1);
        model_clear(w);
        idle_cycles(w, 2);
    endtask

    // Issue one request and check every cycle until it completes. If abort
    // is a cycle index, reset is pulled low between edges after that cycle.
    task automatic run_req(int w, int k, bit s, int abort);
        int         nph;
        int         d;
        int         hold;
        int         len;
        logic [7:0] kb, jb, c, o;
        nph = n_ph[w];
        d   = dw[w];
        exp_q.delete();
        clr_q.delete();
        kb = 8'd1 << k;
        jb = 8'd1 << m_j[w];
        if (k > nph) begin
            hold = $urandom_range(1, 4);
            for (int i = 0; i < hold; i++) push('0, '0, 1'b0, 1'b0, 1'b1, i == hold - 1);
            push('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
            model_clear(w);
        end else if (!m_on[w]) begin
            if (k == nph) begin
                push('0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
            end else begin
                push(kb, kb, 1'b1, 1'b1, 1'b0, 1'b0);
                m_on[w] = 1'b1; m_j[w] = k; m_gp[w] = kb; m_gn[w] = kb;
            end
        end else if (k == m_j[w]) begin
            push(m_gp[w], m_gn[w], 1'b1, 1'b1, 1'b0, 1'b0);
        end else begin
            c = s ? m_gp[w] : m_gn[w];
            o = s ? m_gn[w] : m_gp[w];
            o = o & ~jb;
            for (int i = 0; i < d; i++) push_cs(s, c, o, 1'b0, 1'b0);
            if (k == nph) begin
                push('0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
                model_clear(w);
            end else begin
                c = c | kb;
                for (int i = 0; i < d; i++) push_cs(s, c, o, 1'b0, 1'b0);
                c = c & ~jb;
                for (int i = 0; i < d; i++) push_cs(s, c, o, 1'b0, 1'b0);
                o = o | kb;
                push_cs(s, c, o, 1'b1, 1'b1);
                m_j[w]  = k;
                m_gp[w] = s ? c : o;
                m_gn[w] = s ? o : c;
            end
        end
        len = exp_q.size();
        $display("dut%0d request sel=%0d sign=%0d abort_at=%0d cycles=%0d", w, k, s, abort, len);
        drive(w, 1'b1, k, s, 1'b0);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check_eq($sformatf("d%0d sel%0d c%0d", w, k, i), sample(w), exp_q[i]);
            if (i == abort) begin
                drive(w, 1'b0, 0, 1'b0, 1'b0);
                #2;
                set_rst(w, 1'b0);
                #1;
                check_eq($sformatf("d%0d rst_mid_async", w), sample(w), pack_obs('0, '0, 1'b0, 1'b1, 1'b0));
                @(negedge clk);
                check_eq($sformatf("d%0d rst_mid_held", w), sample(w), pack_obs('0, '0, 1'b0, 1'b1, 1'b0));
                set_rst(w, 1'b1);
                model_clear(w);
                break;
            end
            if (exp_q[i][17] == 1'b0) begin
                // Not ready: anything presented now must be ignored, and the
                // sign may change freely.
                if (clr_q[i]) drive(w, 1'b0, 0, 1'b0, 1'b1);
                else drive(w, 1'($urandom), $urandom_range(0, 7), 1'($urandom),
                           exp_q[i][18] ? 1'b0 : 1'($urandom));
            end else begin
                drive(w, 1'b0, 0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        model_clear(0);
        model_clear(1);
        do_reset(0);
        do_reset(1);

        // Directed 3-phase scenarios.
        run_req(0, 0, 1'b1, -1);
        idle_cycles(0, 2);
        run_req(0, 1, 1'b1, -1);
        run_req(0, 2, 1'b0, -1);
        run_req(0, 3, 1'b1, -1);
        idle_cycles(0, 2);
        run_req(0, 3, 1'b0, -1);
        run_req(0, 0, 1'b1, -1);
        run_req(0, 0, 1'b0, -1);
        run_req(0, 1, 1'b1, 5);
        idle_cycles(0, 3);

        repeat (40) begin
            run_req(0, $urandom_range(0, 3), 1'($urandom), -1);
            idle_cycles(0, $urandom_range(0, 2));
        end

        // Directed 5-phase scenarios, including invalid selections.
        run_req(1, 2, 1'b0, -1);
        run_req(1, 7, 1'b1, -1);
        idle_cycles(1, 2);
        run_req(1, 4, 1'b1, -1);
        run_req(1, 6, 1'b0, -1);
        run_req(1, 5, 1'b0, -1);

        repeat (40) begin
            run_req(1, $urandom_range(0, 7), 1'($urandom), -1);
            idle_cycles(1, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
